// File: rtl/screen_ram_ctrl_if.sv
// screen_ram_ctrl_if: CPU write, command, VGA fetch and screen-RAM port signals of screen_ram_ctrl
interface screen_ram_ctrl_if #(parameter int ADDR_W = 12);
    logic              cpu_wr_en;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_data;
    logic              cmd_valid;
    logic [1:0]        cmd_op;
    logic [7:0]        cmd_fill;
    logic              cmd_ready;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] vga_rd_addr;
    logic              vga_blank;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [7:0]        ram_q;
    logic              ram_wr_en;
    logic [ADDR_W-1:0] ram_wr_addr;
    logic [7:0]        ram_wr_data;

    modport master (
        output cpu_wr_en, cpu_addr, cpu_data, cmd_valid, cmd_op, cmd_fill, vga_rd_addr, vga_blank, ram_q,
        input  cmd_ready, busy, done, ram_rd_addr, ram_wr_en, ram_wr_addr, ram_wr_data
    );

    modport slave (
        input  cpu_wr_en, cpu_addr, cpu_data, cmd_valid, cmd_op, cmd_fill, vga_rd_addr, vga_blank, ram_q,
        output cmd_ready, busy, done, ram_rd_addr, ram_wr_en, ram_wr_addr, ram_wr_data
    );
endinterface

// File: rtl/screen_ram_ctrl.sv
// screen_ram_ctrl: screen RAM write/read arbiter with a CLEAR/SCROLL engine.
// SCROLL (SCR_* states, move_data) is built only when SCREEN_SCROLL_EN is defined.
module screen_ram_ctrl #(
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int ADDR_W = 12
) (
    input logic              clk,
    input logic              rst,
    screen_ram_ctrl_if.slave bus
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ROWS * COLS - 1);
`ifdef SCREEN_SCROLL_EN
    localparam logic [ADDR_W-1:0] COPY_LAST = ADDR_W'((ROWS - 1) * COLS - 1);
    typedef enum logic [2:0] {IDLE, CLR, SCR_RD, SCR_LAT, SCR_WR, SCR_FILL, DONE} state_t;
    logic [7:0] move_data;
`else
    typedef enum logic [1:0] {IDLE, CLR, DONE} state_t;
    logic unused_ok;
    assign unused_ok = ^{bus.ram_q, bus.vga_blank};
`endif
    state_t            state, state_nx;
    logic [ADDR_W-1:0] cnt;
    logic [7:0]        fill, eng_data;
    logic              accept, eng_req, eng_we;

    assign accept = bus.cmd_valid && state == IDLE;

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.cmd_valid) state_nx = bus.cmd_op == 2'b01 ? CLR : DONE;
`ifdef SCREEN_SCROLL_EN
                if (bus.cmd_valid && bus.cmd_op == 2'b10) state_nx = SCR_RD;
`endif
            end
            CLR: if (eng_we && cnt == LAST) state_nx = DONE;
`ifdef SCREEN_SCROLL_EN
            SCR_RD: if (bus.vga_blank) state_nx = SCR_LAT;
            // a CPU write in SCR_LAT or SCR_WR parks the copied character in move_data
            SCR_LAT, SCR_WR: state_nx = bus.cpu_wr_en ? SCR_WR : cnt == COPY_LAST ? SCR_FILL : SCR_RD;
            SCR_FILL: if (eng_we && cnt == LAST) state_nx = DONE;
`endif
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
`ifdef SCREEN_SCROLL_EN
        eng_req = state == CLR || state == SCR_LAT || state == SCR_WR || state == SCR_FILL;
        eng_data = state == SCR_LAT ? bus.ram_q : state == SCR_WR ? move_data : fill;
        bus.ram_rd_addr = state == SCR_RD && bus.vga_blank ? cnt + ADDR_W'(COLS) : bus.vga_rd_addr;
`else
        eng_req = state == CLR;
        eng_data = fill;
        bus.ram_rd_addr = bus.vga_rd_addr;
`endif
        eng_we = eng_req && !bus.cpu_wr_en;
        bus.ram_wr_en = bus.cpu_wr_en || eng_req;
        bus.ram_wr_addr = bus.cpu_wr_en ? bus.cpu_addr : eng_req ? cnt : '0;
        bus.ram_wr_data = bus.cpu_wr_en ? bus.cpu_data : eng_req ? eng_data : '0;
        bus.cmd_ready = state == IDLE;
        bus.busy = state != IDLE && state != DONE;
        bus.done = state == DONE;
    end

    // one counter serves as CLEAR address, scroll destination and then fill address
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            fill <= '0;
        end else if (accept) begin
            cnt  <= '0;
            fill <= bus.cmd_fill;
        end else if (eng_we) begin
            cnt  <= cnt + ADDR_W'(1);
        end
    end

`ifdef SCREEN_SCROLL_EN
    always_ff @(posedge clk)
        move_data <= rst ? '0 : state == SCR_LAT ? bus.ram_q : move_data;
`endif
endmodule
